// File: rtl/dca_matrix_lsu_read_scheduler.sv
// Row-load sequencer for the DCA matrix LSU: one AR burst plus one txn-info word per row, credit-limited.
// Optional DCA_LSU_SCHED_STRIDE0_REUSE_EN: a zero stride issues only row 0's AR and marks later rows skip.
module dca_matrix_lsu_read_scheduler #(
  parameter int BW_ADDR          = 32,
  parameter int MAX_NUM_AXI_DATA = 4,
  parameter int MAX_OUTSTANDING  = 4,
  parameter int BW_NUM_ROW       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [BW_ADDR-1:0]    cmd_addr,
  input  logic [BW_ADDR-1:0]    cmd_stride,
  input  logic [BW_NUM_ROW-1:0] cmd_num_row,
  input  logic [7:0]            cmd_alen,
  output logic                  arvalid,
  input  logic                  arready,
  output logic [BW_ADDR-1:0]    araddr,
  output logic [7:0]            arlen,
  output logic                  txn_valid,
  input  logic                  txn_ready,
  output logic [BW_ADDR+9:0]    txn_info,
  input  logic                  row_done,
  output logic                  busy,
  output logic                  done
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_OUTSTANDING);
  localparam logic [7:0]    ALEN_MAX = 8'(MAX_NUM_AXI_DATA - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_FINISH} state_t;
  state_t state, state_nxt;

  logic [BW_ADDR-1:0]    row_addr, stride;
  logic [7:0]            alen;
  logic [BW_NUM_ROW-1:0] rows_left;
  logic [CW-1:0]         outstanding, out_nxt;
  logic row_active, ar_sent, txn_sent;
  logic accept, ar_hs, txn_hs, dec, retire, skip, last_row;

`ifdef DCA_LSU_SCHED_STRIDE0_REUSE_EN
  logic first_row;
  assign skip = (state == S_ISSUE) && (stride == '0) && !first_row;
`else
  assign skip = 1'b0;
`endif

  assign last_row = (rows_left == BW_NUM_ROW'(1));

  always_comb begin
    accept = enable && cmd_valid && cmd_ready;
    ar_hs  = enable && arvalid && arready;
    txn_hs = enable && txn_valid && txn_ready;
    dec    = enable && row_done && (outstanding != '0);
    // a row retires on the cycle its last outstanding handshake lands
    retire = enable && row_active && (ar_sent || ar_hs || skip) && (txn_sent || txn_hs);
    out_nxt = outstanding;
    case ({txn_hs, dec})
      2'b10:   out_nxt = outstanding + 1'b1;
      2'b01:   out_nxt = outstanding - 1'b1;
      default: out_nxt = outstanding;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept) state_nxt = (cmd_num_row == '0) ? S_FINISH : S_ISSUE;
      S_ISSUE:  if (retire && last_row) state_nxt = S_DRAIN;
      S_DRAIN:  if (enable && outstanding == '0) state_nxt = S_FINISH;
      S_FINISH: if (enable) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == S_IDLE);
    busy      = (state != S_IDLE);
    done      = (state == S_FINISH);
    arvalid   = row_active && !ar_sent && !skip;
    txn_valid = row_active && !txn_sent;
    araddr    = row_addr;
    arlen     = alen;
    txn_info  = {skip, last_row, alen, row_addr};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_addr    <= '0;
      stride      <= '0;
      alen        <= '0;
      rows_left   <= '0;
      outstanding <= '0;
      row_active  <= 1'b0;
      ar_sent     <= 1'b0;
      txn_sent    <= 1'b0;
`ifdef DCA_LSU_SCHED_STRIDE0_REUSE_EN
      first_row   <= 1'b0;
`endif
    end else if (enable) begin
      outstanding <= out_nxt;
      if (accept) begin
        row_addr   <= cmd_addr;
        stride     <= cmd_stride;
        alen       <= (cmd_alen > ALEN_MAX) ? ALEN_MAX : cmd_alen;
        rows_left  <= cmd_num_row;
        row_active <= (cmd_num_row != '0);
        ar_sent    <= 1'b0;
        txn_sent   <= 1'b0;
`ifdef DCA_LSU_SCHED_STRIDE0_REUSE_EN
        first_row  <= 1'b1;
`endif
      end else if (state == S_ISSUE) begin
        if (retire) begin
          row_addr   <= row_addr + stride;
          rows_left  <= rows_left - 1'b1;
          ar_sent    <= 1'b0;
          txn_sent   <= 1'b0;
          // next row's valids launch straight from this retirement when credit remains
          row_active <= !last_row && (out_nxt < MAX_CNT);
`ifdef DCA_LSU_SCHED_STRIDE0_REUSE_EN
          first_row  <= 1'b0;
`endif
        end else if (row_active) begin
          ar_sent  <= ar_sent || ar_hs;
          txn_sent <= txn_sent || txn_hs;
        end else begin
          row_active <= (out_nxt < MAX_CNT);
        end
      end
    end
  end
endmodule

// File: tb/tb_dca_matrix_lsu_read_scheduler.sv
// Directed bench for dca_matrix_lsu_read_scheduler with hand-computed expectations.
module tb_dca_matrix_lsu_read_scheduler;
  localparam int BW_ADDR = 32;
  localparam int BW_NUM_ROW = 16;
  localparam int SKIP_B = BW_ADDR + 9;
  localparam int LAST_B = BW_ADDR + 8;

  logic clk = 1'b0;
  logic rst, enable, cmd_valid, cmd_ready, arvalid, arready, txn_valid, txn_ready;
  logic row_done, busy, done;
  logic [BW_ADDR-1:0] cmd_addr, cmd_stride, araddr;
  logic [BW_NUM_ROW-1:0] cmd_num_row;
  logic [7:0] cmd_alen, arlen;
  logic [BW_ADDR+9:0] txn_info;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  dca_matrix_lsu_read_scheduler dut (
    .clk(clk), .rst(rst), .enable(enable),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_stride(cmd_stride), .cmd_num_row(cmd_num_row), .cmd_alen(cmd_alen),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
    .txn_valid(txn_valid), .txn_ready(txn_ready), .txn_info(txn_info),
    .row_done(row_done), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] s, input logic [15:0] n, input logic [7:0] l);
    cmd_addr = a; cmd_stride = s; cmd_num_row = n; cmd_alen = l; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input int n, input string tag);
    row_done = 1'b1;
    repeat (n) step();
    row_done = 1'b0;
    chk({tag, "_no_early_done"}, done, 1'b0);
    for (int i = 0; i < 10 && !done; i++) step();
    chk({tag, "_done"}, done, 1'b1);
    step();
    chk({tag, "_done_pulse"}, done, 1'b0);
    chk({tag, "_ready_back"}, cmd_ready, 1'b1);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_stride = '0;
    cmd_num_row = '0; cmd_alen = '0; arready = 1'b0; txn_ready = 1'b0; row_done = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_arvalid", arvalid, 1'b0);
    chk("rst_txn_valid", txn_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_txn_info", txn_info, '0);

    // three rows back to back
    arready = 1'b1; txn_ready = 1'b1;
    issue(32'h1000, 32'h40, 16'd3, 8'd3);
    chk("t1_r0_arvalid", arvalid, 1'b1);
    chk("t1_r0_txn_valid", txn_valid, 1'b1);
    chk("t1_r0_info", txn_info, {1'b0, 1'b0, 8'h03, 32'h1000});
    chk("t1_arlen", arlen, 8'd3);
    chk("t1_cmd_ready", cmd_ready, 1'b0);
    chk("t1_busy", busy, 1'b1);
    step();
    chk("t1_r1_addr", araddr, 32'h1040);
    chk("t1_r1_last", txn_info[LAST_B], 1'b0);
    step();
    chk("t1_r2_addr", araddr, 32'h1080);
    chk("t1_r2_last", txn_info[LAST_B], 1'b1);
    chk("t1_r2_valid", arvalid & txn_valid, 1'b1);
    step();
    chk("t1_drain_arvalid", arvalid, 1'b0);
    chk("t1_drain_txn_valid", txn_valid, 1'b0);
    drain(3, "t1");

    // credit limit: 4 rows in flight, then stall
    issue(32'h0, 32'h10, 16'd6, 8'd0);
    for (int i = 0; i < 4; i++) begin
      chk("t2_txn_valid", txn_valid, 1'b1);
      chk("t2_addr", araddr, 32'(i * 16));
      step();
    end
    chk("t2_stall_txn", txn_valid, 1'b0);
    chk("t2_stall_ar", arvalid, 1'b0);
    step();
    chk("t2_stall2_txn", txn_valid, 1'b0);
    row_done = 1'b1;
    step();
    row_done = 1'b0;
    chk("t2_r4_txn", txn_valid, 1'b1);
    chk("t2_r4_addr", araddr, 32'h40);
    step();
    chk("t2_restall", txn_valid, 1'b0);
    row_done = 1'b1;
    step();
    row_done = 1'b0;
    chk("t2_r5_addr", araddr, 32'h50);
    chk("t2_r5_last", txn_info[LAST_B], 1'b1);
    step();
    drain(4, "t2");

    // AR back-pressure; a ready seen with enable low must not count
    arready = 1'b0;
    issue(32'h2000, 32'h100, 16'd2, 8'd1);
    chk("t3_both_valid", arvalid & txn_valid, 1'b1);
    step();
    chk("t3_txn_dropped", txn_valid, 1'b0);
    chk("t3_ar_held", arvalid, 1'b1);
    enable = 1'b0; arready = 1'b1;
    step();
    enable = 1'b1; arready = 1'b0;
    chk("t3_en_low_ar_held", arvalid, 1'b1);
    chk("t3_addr_stable", araddr, 32'h2000);
    step();
    chk("t3_ar_still", arvalid, 1'b1);
    arready = 1'b1;
    step();
    chk("t3_r1_both", arvalid & txn_valid, 1'b1);
    chk("t3_r1_addr", araddr, 32'h2100);
    step();
    drain(2, "t3");

    // zero rows
    issue(32'h5000, 32'h10, 16'd0, 8'd2);
    chk("t4_done", done, 1'b1);
    chk("t4_no_valid", arvalid | txn_valid, 1'b0);
    chk("t4_cmd_ready", cmd_ready, 1'b0);
    step();
    chk("t4_done_gone", done, 1'b0);
    chk("t4_ready_back", cmd_ready, 1'b1);

    // reset mid-row
    arready = 1'b0; txn_ready = 1'b0;
    issue(32'h6000, 32'h10, 16'd2, 8'd1);
    chk("t5_arvalid", arvalid, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_rst_ar", arvalid, 1'b0);
    chk("t5_rst_txn", txn_valid, 1'b0);
    chk("t5_rst_ready", cmd_ready, 1'b1);
    chk("t5_rst_done", done, 1'b0);
    chk("t5_rst_addr", araddr, '0);
    chk("t5_rst_arlen", arlen, '0);
    arready = 1'b1; txn_ready = 1'b1;
    issue(32'h3000, 32'h10, 16'd1, 8'd2);
    chk("t5_new_info", txn_info, {1'b0, 1'b1, 8'h02, 32'h3000});
    step();
    drain(1, "t5");

    // zero stride
    issue(32'h4000, 32'h0, 16'd4, 8'd0);
    chk("t6_r0_ar", arvalid, 1'b1);
    chk("t6_r0_skip", txn_info[SKIP_B], 1'b0);
    for (int i = 1; i < 4; i++) begin
      step();
      chk("t6_txn", txn_valid, 1'b1);
      chk("t6_addr", araddr, 32'h4000);
`ifdef DCA_LSU_SCHED_STRIDE0_REUSE_EN
      chk("t6_ar_suppressed", arvalid, 1'b0);
      chk("t6_skip", txn_info[SKIP_B], 1'b1);
`else
      chk("t6_ar", arvalid, 1'b1);
      chk("t6_skip", txn_info[SKIP_B], 1'b0);
`endif
    end
    step();
    chk("t6_idle_valids", arvalid | txn_valid, 1'b0);
    drain(4, "t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
